// File: rtl/fp32_mac_dot_sequencer.sv
// Dot-product sequencer: streams (a, b) pairs through an external FP32 MAC,
// feeding each delta back as the next acc, and hands the sum to the TX side.
module fp32_mac_dot_sequencer #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic             CLK_I,
    input  logic             RSTL_I,
    input  logic             OP_VALID_I,
    output logic             OP_READY_O,
    input  logic [31:0]      OP_A_I,
    input  logic [31:0]      OP_B_I,
    input  logic             OP_LAST_I,
    output logic [31:0]      MAC_ALPHA_O,
    output logic [31:0]      MAC_BRAVO_O,
    output logic [31:0]      MAC_ACC_O,
    output logic             MAC_START_O,
    input  logic             MAC_DONE_I,
    input  logic [31:0]      MAC_DELTA_I,
    output logic             RES_VALID_O,
    input  logic             RES_READY_I,
    output logic [31:0]      RES_DATA_O,
    output logic [CNT_W-1:0] RES_COUNT_O,
    output logic             RES_TIMEOUT_O,
    output logic             BUSY_O,
    output logic [2:0]       DBG_STATE_O
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid-side data is held stable while valid is high and ready low.

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FETCH  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_RESULT = 3'd5
    } state_t;

    state_t            state;
    logic              last_q;
    logic              to_flag;
    logic              done_prev;
    logic [TW-1:0]     timer;
    logic [CNT_W-1:0]  count;

    logic              done_edge;
    logic              op_hs;
    logic              res_hs;
    logic              timeout_hit;
    logic [CNT_W-1:0]  count_inc;

    assign done_edge   = MAC_DONE_I & ~done_prev;
    assign op_hs       = OP_VALID_I & OP_READY_O;
    assign res_hs      = RES_VALID_O & RES_READY_I;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (timer == TO_LAST);
    assign count_inc   = (&count) ? count : count + CNT_W'(1);

    assign BUSY_O      = (state != ST_IDLE);
    assign DBG_STATE_O = state;

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state         <= ST_IDLE;
            OP_READY_O    <= 1'b0;
            MAC_ALPHA_O   <= '0;
            MAC_BRAVO_O   <= '0;
            MAC_ACC_O     <= '0;
            MAC_START_O   <= 1'b0;
            RES_VALID_O   <= 1'b0;
            RES_DATA_O    <= '0;
            RES_COUNT_O   <= '0;
            RES_TIMEOUT_O <= 1'b0;
            last_q        <= 1'b0;
            to_flag       <= 1'b0;
            done_prev     <= 1'b0;
            timer         <= '0;
            count         <= '0;
        end else begin
            done_prev <= MAC_DONE_I;
            case (state)
                ST_IDLE: begin
                    OP_READY_O <= 1'b1;
                    if (op_hs) begin
                        MAC_ALPHA_O <= OP_A_I;
                        MAC_BRAVO_O <= OP_B_I;
                        last_q      <= OP_LAST_I;
                        MAC_ACC_O   <= '0;
                        count       <= '0;
                        to_flag     <= 1'b0;
                        OP_READY_O  <= 1'b0;
                        MAC_START_O <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    // Dropping start here guarantees a fresh rising edge per op.
                    MAC_START_O <= 1'b0;
                    timer       <= '0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_edge) begin
                        MAC_ACC_O <= MAC_DELTA_I;
                        count     <= count_inc;
                        if (last_q) begin
                            RES_VALID_O   <= 1'b1;
                            RES_DATA_O    <= MAC_DELTA_I;
                            RES_COUNT_O   <= count_inc;
                            RES_TIMEOUT_O <= to_flag;
                            state         <= ST_RESULT;
                        end else begin
                            OP_READY_O <= 1'b1;
                            state      <= ST_FETCH;
                        end
                    end else if (timeout_hit) begin
                        to_flag <= 1'b1;
                        if (last_q) begin
                            RES_VALID_O   <= 1'b1;
                            RES_DATA_O    <= MAC_ACC_O;
                            RES_COUNT_O   <= count;
                            RES_TIMEOUT_O <= 1'b1;
                            state         <= ST_RESULT;
                        end else begin
                            OP_READY_O <= 1'b1;
                            state      <= ST_DRAIN;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_FETCH: begin
                    if (op_hs) begin
                        MAC_ALPHA_O <= OP_A_I;
                        MAC_BRAVO_O <= OP_B_I;
                        last_q      <= OP_LAST_I;
                        OP_READY_O  <= 1'b0;
                        MAC_START_O <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_DRAIN: begin
                    // Remaining pairs of an aborted vector are swallowed unused.
                    if (op_hs && OP_LAST_I) begin
                        OP_READY_O    <= 1'b0;
                        RES_VALID_O   <= 1'b1;
                        RES_DATA_O    <= MAC_ACC_O;
                        RES_COUNT_O   <= count;
                        RES_TIMEOUT_O <= to_flag;
                        state         <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_hs) begin
                        RES_VALID_O <= 1'b0;
                        to_flag     <= 1'b0;
                        OP_READY_O  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    OP_READY_O <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_mac_dot_sequencer.sv
// Directed bench for fp32_mac_dot_sequencer with a 20-cycle behavioural MAC.
module tb_fp32_mac_dot_sequencer;

    localparam int CNT_W   = 16;
    localparam int MAC_LAT = 20;
    localparam int BOUND   = 400;

    logic             CLK_I = 1'b0;
    logic             RSTL_I = 1'b0;
    logic             OP_VALID_I = 1'b0;
    logic             OP_READY_O;
    logic [31:0]      OP_A_I = '0;
    logic [31:0]      OP_B_I = '0;
    logic             OP_LAST_I = 1'b0;
    logic [31:0]      MAC_ALPHA_O;
    logic [31:0]      MAC_BRAVO_O;
    logic [31:0]      MAC_ACC_O;
    logic             MAC_START_O;
    logic             MAC_DONE_I;
    logic [31:0]      MAC_DELTA_I;
    logic             RES_VALID_O;
    logic             RES_READY_I = 1'b0;
    logic [31:0]      RES_DATA_O;
    logic [CNT_W-1:0] RES_COUNT_O;
    logic             RES_TIMEOUT_O;
    logic             BUSY_O;
    logic [2:0]       DBG_STATE_O;

    int total = 0;
    int bad   = 0;

    fp32_mac_dot_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYC(64)) dut (
        .CLK_I(CLK_I), .RSTL_I(RSTL_I),
        .OP_VALID_I(OP_VALID_I), .OP_READY_O(OP_READY_O),
        .OP_A_I(OP_A_I), .OP_B_I(OP_B_I), .OP_LAST_I(OP_LAST_I),
        .MAC_ALPHA_O(MAC_ALPHA_O), .MAC_BRAVO_O(MAC_BRAVO_O), .MAC_ACC_O(MAC_ACC_O),
        .MAC_START_O(MAC_START_O), .MAC_DONE_I(MAC_DONE_I), .MAC_DELTA_I(MAC_DELTA_I),
        .RES_VALID_O(RES_VALID_O), .RES_READY_I(RES_READY_I), .RES_DATA_O(RES_DATA_O),
        .RES_COUNT_O(RES_COUNT_O), .RES_TIMEOUT_O(RES_TIMEOUT_O),
        .BUSY_O(BUSY_O), .DBG_STATE_O(DBG_STATE_O)
    );

    // ---------------- clock ----------------
    always #5 CLK_I = ~CLK_I;

    // ---------------- fp32 helpers (normal numbers and +/-0 only) ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], {3'd0, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // ---------------- behavioural MAC ----------------
    logic        mac_mute  = 1'b0;
    logic        stale_req = 1'b0;
    logic        mac_busy;
    logic        start_prev;
    int          lat_cnt;
    logic [31:0] launch_q[$];

    always @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            MAC_DONE_I  <= 1'b0;
            MAC_DELTA_I <= '0;
            mac_busy    <= 1'b0;
            start_prev  <= 1'b0;
            lat_cnt     <= 0;
        end else begin
            start_prev <= MAC_START_O;
            if (MAC_START_O && !start_prev) begin
                mac_busy   <= 1'b1;
                lat_cnt    <= MAC_LAT - 1;
                MAC_DONE_I <= 1'b0;
                launch_q.push_back(MAC_ACC_O);
            end else if (mac_busy) begin
                if (lat_cnt == 0) begin
                    mac_busy <= 1'b0;
                    if (!mac_mute) begin
                        MAC_DONE_I  <= 1'b1;
                        MAC_DELTA_I <= r2f(f2r(MAC_ALPHA_O) * f2r(MAC_BRAVO_O) + f2r(MAC_ACC_O));
                    end
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end else if (stale_req) begin
                MAC_DONE_I  <= 1'b1;
                MAC_DELTA_I <= 32'hDEADBEEF;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        int               n;
        logic [2:0][31:0] a;
        logic [2:0][31:0] b;
        logic             mute;
        logic [31:0]      exp_data;
        logic [15:0]      exp_cnt;
        logic             exp_to;
        int               exp_starts;
        logic [2:0][31:0] exp_acc;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mkvec(input int n,
                                   input logic [31:0] a0, b0, a1, b1, a2, b2,
                                   input logic mute, input logic [31:0] d,
                                   input logic [15:0] c, input logic t, input int ns,
                                   input logic [31:0] e0, e1, e2);
        vec_t v;
        v.n = n; v.mute = mute; v.exp_data = d; v.exp_cnt = c; v.exp_to = t;
        v.exp_starts = ns;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.exp_acc[0] = e0; v.exp_acc[1] = e1; v.exp_acc[2] = e2;
        return v;
    endfunction

    // ---------------- scoreboard / checks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
        int k;
        @(negedge CLK_I);
        OP_VALID_I = 1'b1; OP_A_I = a; OP_B_I = b; OP_LAST_I = last;
        k = 0;
        while (!OP_READY_O && k < BOUND) begin
            @(negedge CLK_I);
            k++;
        end
        if (k >= BOUND) check("op_ready_wait", 64'd0, 64'd1);
        @(posedge CLK_I);
        #1 OP_VALID_I = 1'b0;
    endtask

    task automatic wait_res_valid();
        int k;
        k = 0;
        @(negedge CLK_I);
        while (!RES_VALID_O && k < BOUND) begin
            @(negedge CLK_I);
            k++;
        end
        if (k >= BOUND) check("res_valid_wait", 64'd0, 64'd1);
    endtask

    task automatic send_vec(input int idx);
        launch_q.delete();
        mac_mute = vecs[idx].mute;
        for (int i = 0; i < vecs[idx].n; i++)
            send_pair(vecs[idx].a[i], vecs[idx].b[i], i == vecs[idx].n - 1);
    endtask

    task automatic check_vec(input int idx);
        check($sformatf("v%0d_data", idx), 64'(RES_DATA_O), 64'(vecs[idx].exp_data));
        check($sformatf("v%0d_count", idx), 64'(RES_COUNT_O), 64'(vecs[idx].exp_cnt));
        check($sformatf("v%0d_timeout", idx), 64'(RES_TIMEOUT_O), 64'(vecs[idx].exp_to));
        check($sformatf("v%0d_starts", idx), 64'(launch_q.size()), 64'(vecs[idx].exp_starts));
        for (int i = 0; i < vecs[idx].exp_starts && i < launch_q.size(); i++)
            check($sformatf("v%0d_acc_at_start%0d", idx, i), 64'(launch_q[i]),
                  64'(vecs[idx].exp_acc[i]));
    endtask

    task automatic run_vec(input int idx);
        RES_READY_I = 1'b1;
        send_vec(idx);
        wait_res_valid();
        check_vec(idx);
        @(posedge CLK_I);
        @(negedge CLK_I);
        check($sformatf("v%0d_valid_drop", idx), 64'(RES_VALID_O), 64'd0);
        check($sformatf("v%0d_ready_idle", idx), 64'(OP_READY_O), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] held_data;
        logic [15:0] held_cnt;
        logic        unstable;

        vecs[0] = mkvec(1, 32'hBF000000, 32'h3F400000, 0, 0, 0, 0,
                        1'b0, 32'hBEC00000, 16'd1, 1'b0, 1, 32'h0, 32'h0, 32'h0);
        vecs[1] = mkvec(2, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 0,
                        1'b0, 32'h41600000, 16'd2, 1'b0, 2, 32'h0, 32'h40000000, 32'h0);
        vecs[2] = mkvec(3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                        32'h3F800000, 32'h3F800000,
                        1'b1, 32'h00000000, 16'd0, 1'b1, 1, 32'h0, 32'h0, 32'h0);
        vecs[3] = mkvec(3, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h40800000,
                        32'hC0400000, 32'h3F800000,
                        1'b0, 32'h40400000, 16'd3, 1'b0, 3, 32'h0, 32'h40800000, 32'h40C00000);
        vecs[4] = mkvec(1, 32'h00000000, 32'h40000000, 0, 0, 0, 0,
                        1'b0, 32'h00000000, 16'd1, 1'b0, 1, 32'h0, 32'h0, 32'h0);

        // reset state
        #12;
        check("reset_outputs_low", 64'(|{OP_READY_O, MAC_START_O, RES_VALID_O, BUSY_O,
              MAC_ACC_O, RES_DATA_O, RES_COUNT_O}), 64'd0);
        @(negedge CLK_I);
        RSTL_I = 1'b1;
        @(negedge CLK_I);
        check("post_reset_state", 64'(DBG_STATE_O), 64'd0);
        check("post_reset_ready", 64'(OP_READY_O), 64'd1);

        // table: single pair, two pairs, timeout+drain, three pairs, zero operand
        for (int v = 0; v < 5; v++) run_vec(v);

        // stale done level held high before the first start
        @(negedge CLK_I);
        stale_req = 1'b1;
        repeat (3) @(negedge CLK_I);
        stale_req = 1'b0;
        run_vec(0);

        // result backpressure for 100 cycles
        RES_READY_I = 1'b0;
        send_vec(1);
        wait_res_valid();
        check_vec(1);
        held_data = RES_DATA_O;
        held_cnt  = RES_COUNT_O;
        unstable  = 1'b0;
        repeat (100) begin
            @(negedge CLK_I);
            if (RES_VALID_O !== 1'b1 || RES_DATA_O !== held_data ||
                RES_COUNT_O !== held_cnt || OP_READY_O !== 1'b0)
                unstable = 1'b1;
        end
        check("backpressure_hold", 64'(unstable), 64'd0);
        RES_READY_I = 1'b1;
        @(posedge CLK_I);
        @(negedge CLK_I);
        check("release_state_idle", 64'(DBG_STATE_O), 64'd0);
        check("release_ready", 64'(OP_READY_O), 64'd1);
        run_vec(1);

        // asynchronous reset in WAIT mid-vector
        mac_mute = 1'b0;
        send_pair(32'h3F800000, 32'h3F800000, 1'b0);
        repeat (5) @(negedge CLK_I);
        check("in_wait_before_reset", 64'(DBG_STATE_O), 64'd2);
        #2 RSTL_I = 1'b0;
        #1;
        check("midwait_reset_outputs", 64'(|{OP_READY_O, MAC_ALPHA_O, MAC_BRAVO_O, MAC_ACC_O,
              MAC_START_O, RES_VALID_O, RES_DATA_O, RES_COUNT_O, RES_TIMEOUT_O, BUSY_O,
              DBG_STATE_O}), 64'd0);
        @(negedge CLK_I);
        RSTL_I = 1'b1;
        @(negedge CLK_I);
        check("after_reset_idle", 64'(DBG_STATE_O), 64'd0);
        check("after_reset_ready", 64'(OP_READY_O), 64'd1);
        run_vec(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp32_mac_dot_sequencer.md
Name: fp32_mac_dot_sequencer

Overview:
Sequences the FP32 multiply-accumulate unit to compute a dot product over a stream of operand pairs (a_i, b_i) arriving from the RX side. The result goes to the TX side through a valid/ready handshake.
- Per pair, drives alpha/bravo/acc into the MAC, issues a start edge, waits for the MAC done edge, and feeds delta back as the next acc.
- Sits between the UART RX deframer and the MAC, and between the MAC and the UART TX framer.

Parameters:
CNT_W, 16, width of the element counter and RES_COUNT_O.
TIMEOUT_CYC, 16384, max cycles to wait for the MAC done edge after a start (the MAC needs about 10420 cycles at default config); 0 disables timeout.

Ports:
CLK_I  in  1  system clock; all logic on its rising edge.
RSTL_I  in  1  asynchronous active-low reset.
OP_VALID_I  in  1  operand pair valid.
OP_READY_O  out  1  sequencer accepts a pair this cycle.
OP_A_I  in  32  FP32 operand a.
OP_B_I  in  32  FP32 operand b.
OP_LAST_I  in  1  pair is the last of the vector.
MAC_ALPHA_O  out  32  to MAC alpha (registered).
MAC_BRAVO_O  out  32  to MAC bravo (registered).
MAC_ACC_O  out  32  to MAC acc (registered running sum).
MAC_START_O  out  1  to MAC_VALID_I; rising edge launches one MAC op.
MAC_DONE_I  in  1  from MAC_VALID_O; a 0->1 edge marks delta valid.
MAC_DELTA_I  in  32  from MAC delta.
RES_VALID_O  out  1  result valid.
RES_READY_I  in  1  TX accepts result.
RES_DATA_O  out  32  FP32 dot-product result.
RES_COUNT_O  out  CNT_W  pairs accumulated into RES_DATA_O.
RES_TIMEOUT_O  out  1  result aborted by MAC timeout.
BUSY_O  out  1  high in any state other than IDLE.

Behaviour:
Reset (RSTL_I low, asynchronous, including mid-operation):
- State = IDLE; all outputs 0; acc = 0; count = 0; timer = 0; done_prev = 0.
- The MAC shares RSTL_I, so both restart together.

done_prev register:
- Samples MAC_DONE_I every cycle in every state.
- done_edge = MAC_DONE_I & ~done_prev.

IDLE:
- OP_READY_O = 1.
- On handshake (OP_VALID_I & OP_READY_O): latch A/B into MAC_ALPHA_O/MAC_BRAVO_O, latch OP_LAST_I into last_q, set acc = 0 and count = 0, go to START.

START (1 cycle):
- OP_READY_O = 0; MAC_START_O = 1; timer = 0; go to WAIT.

WAIT:
- MAC_START_O = 0 (this guarantees a fresh edge for the next op).
- MAC_ALPHA_O, MAC_BRAVO_O and MAC_ACC_O are held stable for the whole wait, because the MAC resamples them throughout its compute.
- On done_edge: acc = MAC_DELTA_I; count = count + 1, saturating at 2^CNT_W-1. If last_q, go to RESULT; else go to FETCH.
- A stale high MAC_DONE_I at entry is ignored; only a new 0->1 edge counts.
- Timeout (TIMEOUT_CYC ≠ 0): timer increments each WAIT cycle. When timer = TIMEOUT_CYC-1 with no done_edge: set to_flag = 1. If last_q, go to RESULT; else go to DRAIN.
- If done_edge and timeout occur in the same cycle, done_edge wins.

FETCH:
- OP_READY_O = 1.
- On handshake: latch A/B and last_q, go to START. acc is already on MAC_ACC_O.

DRAIN:
- OP_READY_O = 1; discard pairs until a handshake with OP_LAST_I = 1, then go to RESULT.

RESULT:
- RES_VALID_O = 1; RES_DATA_O = acc; RES_COUNT_O = count; RES_TIMEOUT_O = to_flag; OP_READY_O = 0.
- Outputs are held stable until RES_READY_I.
- On handshake: RES_VALID_O = 0 next cycle, to_flag = 0, go to IDLE.
- RES_READY_I may already be high on entry; the handshake then completes in the first RESULT cycle.

Other rules:
- A single-pair vector (OP_LAST_I = 1 on the first pair) gives acc = a*b + 0.
- OP_A_I/OP_B_I are sampled only on handshake.
- Handshake-to-start latency is 1 cycle; done_edge-to-RES_VALID_O latency is 1 cycle.

Test Plan:
1. Bench uses a behavioural MAC model with 20-cycle latency. Single pair a=0xBF000000, b=0x3F400000, last=1 -> RES_DATA_O=0xBEC00000, RES_COUNT_O=1, RES_TIMEOUT_O=0. Exactly one MAC_START_O pulse.
2. Pairs (0x3F800000, 0x40000000), then (0x40400000, 0x40800000) with last -> second launch shows MAC_ACC_O=0x40000000. RES_DATA_O=0x41600000 (14.0), count=2.
3. MAC_DONE_I held high before the first start (MAC in its IDLE) -> the sequencer waits for the fall and then the new rise; acc is not updated from the stale level.
4. MAC model never raises done, TIMEOUT_CYC=64, three-pair vector -> timeout fires in WAIT of pair 1, remaining 2 pairs are drained. Result: RES_TIMEOUT_O=1, count=0, RES_DATA_O=0x00000000.
5. RES_READY_I held low for 100 cycles -> RES_* stable, OP_READY_O=0; on release, return to IDLE in 1 cycle and accept the next vector with acc restarted at 0.
6. Assert RSTL_I low in WAIT mid-vector -> all outputs 0 immediately. After release: state IDLE, OP_READY_O=1, and the next vector computes correctly.
